// File: rtl/counter_seq_ctrl.sv
// Sequencer for the lab 4-bit counter: load a start value, count a programmed number of wrap rounds, pulse done.
// Optional abort input/aborted output enabled by defining CNT_SEQ_CTRL_ABORT_EN.
module counter_seq_ctrl #(
   parameter int RND_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic [3:0]       start_val,
   input  logic [RND_W-1:0] rounds,
   input  logic [3:0]       cnt_q,
   input  logic             cnt_rc,
`ifdef CNT_SEQ_CTRL_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             cnt_ld,
   output logic             cnt_ce,
   output logic [3:0]       cnt_d,
   output logic             busy,
   output logic             done,
   output logic [RND_W-1:0] rnd_left
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state, state_n;
   logic [3:0]       d_n;
   logic [RND_W-1:0] rnd_n;
   logic             abort_req;
   logic             active;
   logic             wrap;
   logic             unused_cnt_q;

   // Counter state is observed for debug only; nothing in the control path depends on it.
   assign unused_cnt_q = ^cnt_q;

`ifdef CNT_SEQ_CTRL_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign active   = (state == LOAD) || (state == RUN);
   assign cnt_ce   = (state == RUN) && !pause && !abort_req;
   assign wrap     = cnt_ce && cnt_rc;
   assign cnt_ld   = (state == LOAD);
   assign busy     = active;
   assign done     = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt_d    <= 4'd0;
         rnd_left <= '0;
      end else begin
         state    <= state_n;
         cnt_d    <= d_n;
         rnd_left <= rnd_n;
      end
   end

   always_comb begin
      state_n = state;
      d_n     = cnt_d;
      rnd_n   = rnd_left;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = LOAD;
               d_n     = start_val;
               rnd_n   = rounds;
            end
         end
         LOAD: begin
            if (abort_req) begin
               state_n = IDLE;
               rnd_n   = '0;
            end else if (rnd_left == '0) begin
               state_n = DONE;
            end else begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (abort_req) begin
               state_n = IDLE;
               rnd_n   = '0;
            end else if (wrap && (rnd_left != '0)) begin
               rnd_n = rnd_left - RND_W'(1);
               if (rnd_left == RND_W'(1)) state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

`ifdef CNT_SEQ_CTRL_ABORT_EN
   // One-cycle pulse in the IDLE cycle that follows an accepted abort.
   always_ff @(posedge clk) begin
      if (rst) aborted <= 1'b0;
      else     aborted <= abort && active;
   end
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl, coupled to a behavioural 4-bit counter.
// Abort scenario is built only when CNT_SEQ_CTRL_ABORT_EN is defined.
module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, pause, abort;
   logic [3:0] start_val, rounds;
   logic [3:0] q = 4'd0;
   logic       rc;
   logic       cnt_ld, cnt_ce, busy, done, aborted;
   logic [3:0] cnt_d, rnd_left;

`ifdef CNT_SEQ_CTRL_ABORT_EN
   localparam bit HAS_ABORT = 1'b1;
`else
   localparam bit HAS_ABORT = 1'b0;
   assign aborted = 1'b0;
`endif

   always #5 clk = ~clk;

   counter_seq_ctrl #(.RND_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause),
      .start_val(start_val), .rounds(rounds), .cnt_q(q), .cnt_rc(rc),
`ifdef CNT_SEQ_CTRL_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .cnt_ld(cnt_ld), .cnt_ce(cnt_ce), .cnt_d(cnt_d), .busy(busy),
      .done(done), .rnd_left(rnd_left)
   );

   // Lab counter: load wins over enable, Rc is terminal count regardless of enable.
   assign rc = (q == 4'hF);
   always @(posedge clk) begin
      if (cnt_ld)      q <= cnt_d;
      else if (cnt_ce) q <= q + 4'd1;
   end

   int checks = 0, failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Model: a transaction is a load cycle, then a budget of enabled cycles, then a done cycle.
   bit         chk_en = 1'b0;
   bit         m_ld = 1'b0, m_done = 1'b0, m_ab = 1'b0;
   int         m_rem = 0, m_r = 0;
   logic [3:0] m_d = 4'd0;
   int         ce_cnt, busy_cnt, run_cnt, done_cnt, ab_cnt, ld_cnt, done_cyc;
   logic [3:0] done_q;

   always @(negedge clk) begin
      if (chk_en) begin
         bit ab_eff, ab_now, exp_ce;
         int exp_rnd;
         ab_eff  = HAS_ABORT && (abort === 1'b1);
         ab_now  = ab_eff && (m_ld || m_rem > 0);
         exp_ce  = (m_rem > 0) && !pause && !ab_eff;
         exp_rnd = m_ld ? m_r : ((m_rem > 0) ? (m_rem + 15) / 16 : 0);
         chk("cnt_ld",   cnt_ld,   m_ld);
         chk("cnt_ce",   cnt_ce,   exp_ce);
         chk("cnt_d",    cnt_d,    m_d);
         chk("busy",     busy,     m_ld || m_rem > 0);
         chk("done",     done,     m_done);
         chk("rnd_left", rnd_left, exp_rnd);
         if (HAS_ABORT) chk("aborted", aborted, m_ab);
         if (cnt_ce) ce_cnt++;
         if (busy) busy_cnt++;
         if (busy && !cnt_ld) run_cnt++;
         if (cnt_ld) ld_cnt++;
         if (aborted) ab_cnt++;
         if (done) begin done_cnt++; done_cyc = cyc; done_q = q; end
         if (rst) begin
            m_ld = 0; m_rem = 0; m_done = 0; m_ab = 0; m_d = 4'd0;
         end else begin
            m_ab = ab_now;
            if (ab_now) begin
               m_ld = 0; m_rem = 0;
            end else if (m_ld) begin
               m_ld = 0;
               if (m_r == 0) m_done = 1;
               else m_rem = (16 - int'(m_d)) + 16 * (m_r - 1);
            end else if (m_rem > 0) begin
               if (exp_ce) begin
                  m_rem--;
                  if (m_rem == 0) m_done = 1;
               end
            end else if (m_done) begin
               m_done = 0;
            end else if (start) begin
               m_ld = 1; m_d = start_val; m_r = int'(rounds);
            end
         end
      end
   end

   int st_cyc;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      ce_cnt = 0; busy_cnt = 0; run_cnt = 0; done_cnt = 0;
      ab_cnt = 0; ld_cnt = 0; done_cyc = -1; done_q = 4'hX;
   endtask

   task automatic go(input logic [3:0] sv, input logic [3:0] r);
      start_val = sv; rounds = r; start = 1'b1; st_cyc = cyc;
      tick();
      start = 1'b0; start_val = 4'($urandom); rounds = 4'($urandom);
   endtask

   task automatic wait_end(input int bound);
      for (int i = 0; i < bound; i++) begin
         tick();
         if (done_cnt > 0 || ab_cnt > 0) break;
      end
      tick(); tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=%0d required=0", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      bit flag;
      rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
      start_val = 4'd9; rounds = 4'd9;
      tick(); tick();
      chk("rst_cnt_ld", cnt_ld, 0);
      chk("rst_cnt_ce", cnt_ce, 0);
      chk("rst_cnt_d", cnt_d, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rnd_left", rnd_left, 0);
      if (HAS_ABORT) chk("rst_aborted", aborted, 0);
      chk_en = 1'b1;
      rst = 1'b0;
      tick();

      // 1: 12, one round
      clr(); go(4'd12, 4'd1); wait_end(30);
      chk("t1_ce_cycles", ce_cnt, 4);
      chk("t1_busy_cycles", busy_cnt, 5);
      chk("t1_done_count", done_cnt, 1);
      chk("t1_q_at_done", done_q, 0);

      // 2: 0, three rounds
      clr(); go(4'd0, 4'd3); wait_end(70);
      chk("t2_ce_cycles", ce_cnt, 48);
      chk("t2_busy_cycles", busy_cnt, 49);
      chk("t2_done_count", done_cnt, 1);
      chk("t2_final_q", q, 0);

      // 3: pause for 5 cycles while Q=10
      clr(); go(4'd8, 4'd1); flag = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (q == 4'd10 && !flag) begin
            pause = 1'b1; flag = 1;
            repeat (4) tick();
            chk("t3_q_held", q, 10);
            tick();
            pause = 1'b0;
         end
         if (done_cnt > 0) break;
      end
      tick(); tick();
      chk("t3_ce_cycles", ce_cnt, 8);
      chk("t3_run_cycles", run_cnt, 13);
      chk("t3_done_count", done_cnt, 1);

      // 4: zero rounds
      clr(); go(4'd5, 4'd0); wait_end(10);
      chk("t4_ce_cycles", ce_cnt, 0);
      chk("t4_final_q", q, 5);
      chk("t4_done_latency", done_cyc - st_cyc, 2);
      chk("t4_done_count", done_cnt, 1);

      // 5: restart ignored mid-run, then rst at Q=7
      clr(); go(4'd3, 4'd2); flag = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (q == 4'd5 && !flag) begin
            start = 1'b1; start_val = 4'd1; rounds = 4'd4; flag = 1;
            tick();
            start = 1'b0;
         end
         if (q == 4'd7) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            break;
         end
      end
      chk("t5_busy", busy, 0);
      chk("t5_cnt_ld", cnt_ld, 0);
      chk("t5_cnt_ce", cnt_ce, 0);
      chk("t5_cnt_d", cnt_d, 0);
      chk("t5_rnd_left", rnd_left, 0);
      tick(); tick();
      chk("t5_done_count", done_cnt, 0);
      chk("t5_load_count", ld_cnt, 1);

`ifdef CNT_SEQ_CTRL_ABORT_EN
      // 6: abort coincident with the final wrap
      clr(); go(4'd14, 4'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (q == 4'hF) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            break;
         end
      end
      chk("t6_aborted", aborted, 1);
      chk("t6_done", done, 0);
      chk("t6_busy", busy, 0);
      tick(); tick();
      chk("t6_done_count", done_cnt, 0);
      chk("t6_abort_count", ab_cnt, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
